fb_dma: RTL

Single-clock framebuffer DMA engine in the SDRAM clock domain, sitting between the SDRAM controller's command/data handshake and the write side of the pixel FIFO feeding the LCD timing generator. It pattern-fills a frame buffer (address-count or constant value), then streams a front buffer continuously into the FIFO in fixed-length read bursts with FIFO-level flow control. It supports double buffering: a swap request exchanges front and back buffer bases exactly at a frame boundary.

---
 rtl/fb_dma_pkg.sv | 32 +++
 rtl/fb_addr_gen.sv | 48 ++++
 rtl/fb_dma.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fb_dma_pkg.sv
// Shared definitions for the framebuffer DMA engine.
// Holds the controller command encodings, the i_Mode encodings and the
// engine state enum. A helper maps an engine state to the controller command
// it issues.
package fb_dma_pkg;

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;

  localparam logic [1:0] MODE_IDLE = 2'd0;
  localparam logic [1:0] MODE_FILL = 2'd1;
  localparam logic [1:0] MODE_SCAN = 2'd2;
  localparam logic [1:0] MODE_RSVD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_FILL_GAP,
    ST_SCAN_WAIT,
    ST_SCAN
  } state_t;

  function automatic logic [1:0] state_cmd(input state_t s);
    case (s)
      ST_FILL: return CMD_WRITE;
      ST_SCAN: return CMD_READ;
      default: return CMD_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Frame offset counter and word address register.
// Ports:
//   clk, reset_n  - clock, synchronous active-low reset
//   clear         - force the offset to 0 (start of a fill)
//   advance       - one word accepted; offset steps, wrapping FRAME_WORDS-1 -> 0
//   base          - base address that applies from the next cycle on
//   offset        - current frame offset (registered)
//   offset_next   - offset that will be loaded on the next edge
//   last          - current offset is the last word of the frame
//   addr          - registered base + offset, modulo 2^ADDR_WIDTH
module fb_addr_gen #(
  parameter int unsigned ADDR_WIDTH   = 22,
  parameter int unsigned FRAME_WORDS  = 384000,
  parameter int unsigned OFFSET_WIDTH = 19
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    advance,
  input  logic [ADDR_WIDTH-1:0]   base,
  output logic [OFFSET_WIDTH-1:0] offset,
  output logic [OFFSET_WIDTH-1:0] offset_next,
  output logic                    last,
  output logic [ADDR_WIDTH-1:0]   addr
);

  assign last = (offset == OFFSET_WIDTH'(FRAME_WORDS - 1));

  always_comb begin
    offset_next = offset;
    if (clear) begin
      offset_next = '0;
    end else if (advance) begin
      offset_next = last ? '0 : offset + OFFSET_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      offset <= '0;
      addr   <= base;
    end else begin
      offset <= offset_next;
      addr   <= base + ADDR_WIDTH'(offset_next);
    end
  end

endmodule

// File: rtl/fb_dma.sv
// Framebuffer DMA engine: pattern-fills the back buffer, then streams the
// front buffer into the pixel FIFO in fixed-length read bursts, with
// frame-boundary front/back swapping.
// Ports:
//   clk, reset_n                 - clock, synchronous active-low reset
//   i_Mode, i_FillConst, i_FillValue, i_FrontBase, i_BackBase, i_Swap - control
//   command, data_address, data_write, data_read, data_read_valid,
//   data_write_done              - SDRAM controller handshake
//   fifo_data, fifo_write, fifo_used - pixel FIFO write side
//   o_Busy, o_FillDone, o_FirstData, o_FrameStart, o_ActiveBuffer - status
module fb_dma
  import fb_dma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 22,
  parameter int unsigned FRAME_WORDS  = 384000,
  parameter int unsigned BURST_LENGTH = 8,
  parameter int unsigned USED_WIDTH   = 10,
  parameter int unsigned FIFO_LIMIT   = 504
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            i_Mode,
  input  logic                  i_FillConst,
  input  logic [DATA_WIDTH-1:0] i_FillValue,
  input  logic [ADDR_WIDTH-1:0] i_FrontBase,
  input  logic [ADDR_WIDTH-1:0] i_BackBase,
  input  logic                  i_Swap,
  output logic [1:0]            command,
  output logic [ADDR_WIDTH-1:0] data_address,
  output logic [DATA_WIDTH-1:0] data_write,
  input  logic [DATA_WIDTH-1:0] data_read,
  input  logic                  data_read_valid,
  input  logic                  data_write_done,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_write,
  input  logic [USED_WIDTH-1:0] fifo_used,
  output logic                  o_Busy,
  output logic                  o_FillDone,
  output logic                  o_FirstData,
  output logic                  o_FrameStart,
  output logic                  o_ActiveBuffer
);

  localparam int unsigned OW     = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int unsigned BW     = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
  // One extra slot of headroom for the fifo_data output register.
  localparam int unsigned THRESH = FIFO_LIMIT - BURST_LENGTH - 1;

  if (FRAME_WORDS % BURST_LENGTH != 0) begin : g_frame_check
    $error("FRAME_WORDS must be a multiple of BURST_LENGTH");
  end

  state_t                  state, state_next;
  logic [BW-1:0]           beat, beat_next;
  logic [ADDR_WIDTH-1:0]   front, back, front_next, back_next, base_sel;
  logic                    pending, pending_next, active_next;
  logic [OW-1:0]           offset, offset_next;
  logic                    last, advance, clear, burst_end;

  logic [1:0]              command_d;
  logic [DATA_WIDTH-1:0]   data_write_d, fifo_data_d;
  logic                    fifo_write_d, frame_start_d, fill_done_d, first_d, busy_d;

  fb_addr_gen #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .FRAME_WORDS (FRAME_WORDS),
    .OFFSET_WIDTH(OW)
  ) u_addr_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .advance    (advance),
    .base       (base_sel),
    .offset     (offset),
    .offset_next(offset_next),
    .last       (last),
    .addr       (data_address)
  );

  assign burst_end = (beat == BW'(BURST_LENGTH - 1));
  assign advance   = ((state == ST_FILL) && data_write_done) ||
                     ((state == ST_SCAN) && data_read_valid);
  assign clear     = (state == ST_IDLE) && (state_next == ST_FILL);

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        unique case (i_Mode)
          MODE_FILL:            state_next = ST_FILL;
          MODE_SCAN:            state_next = ST_SCAN_WAIT;
          MODE_IDLE, MODE_RSVD: state_next = ST_IDLE;
        endcase
      end
      ST_FILL: begin
        if (data_write_done) begin
          if (last)           state_next = ST_IDLE;
          else if (burst_end) state_next = ST_FILL_GAP;
        end
      end
      ST_FILL_GAP: state_next = ST_FILL;
      ST_SCAN_WAIT: begin
        if (i_Mode != MODE_SCAN)              state_next = ST_IDLE;
        else if (32'(fifo_used) <= THRESH)    state_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (data_read_valid && burst_end) state_next = ST_SCAN_WAIT;
      end
    endcase
  end

  // Beat counter, swap bookkeeping and next base selection.
  always_comb begin
    beat_next    = beat;
    pending_next = pending | i_Swap;
    active_next  = o_ActiveBuffer;
    front_next   = front;
    back_next    = back;
    if (state == ST_IDLE) begin
      beat_next = '0;
    end else if (advance) begin
      beat_next = burst_end ? '0 : beat + BW'(1);
    end
    if (state == ST_IDLE) begin
      // A pending swap executes here; bases reload from the inputs on leaving
      // IDLE, mapped through the active-buffer sense so the toggle stays valid.
      active_next  = o_ActiveBuffer ^ pending;
      pending_next = i_Swap;
      if (state_next != ST_IDLE) begin
        front_next = active_next ? i_BackBase  : i_FrontBase;
        back_next  = active_next ? i_FrontBase : i_BackBase;
      end else if (pending) begin
        front_next = back;
        back_next  = front;
      end
    end else if ((state == ST_SCAN) && data_read_valid && last && (pending | i_Swap)) begin
      front_next   = back;
      back_next    = front;
      active_next  = ~o_ActiveBuffer;
      pending_next = 1'b0;
    end
    if (!reset_n)
      base_sel = i_FrontBase;
    else if ((state_next == ST_FILL) || (state_next == ST_FILL_GAP))
      base_sel = back_next;
    else
      base_sel = front_next;
  end

  // Output logic (values registered in the state process).
  always_comb begin
    command_d     = state_cmd(state_next);
    fifo_write_d  = (state == ST_SCAN) && data_read_valid;
    fifo_data_d   = fifo_write_d ? data_read : fifo_data;
    frame_start_d = fifo_write_d && (offset == '0);
    fill_done_d   = (state == ST_FILL) && data_write_done && last;
    first_d       = o_FirstData | fifo_write_d;
    busy_d        = (state_next != ST_IDLE);
    data_write_d  = data_write;
    if ((state_next == ST_FILL) || (state_next == ST_FILL_GAP))
      data_write_d = i_FillConst ? i_FillValue : DATA_WIDTH'(offset_next);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      beat           <= '0;
      front          <= i_FrontBase;
      back           <= i_BackBase;
      pending        <= 1'b0;
      o_ActiveBuffer <= 1'b0;
      command        <= CMD_IDLE;
      data_write     <= '0;
      fifo_data      <= '0;
      fifo_write     <= 1'b0;
      o_Busy         <= 1'b0;
      o_FillDone     <= 1'b0;
      o_FirstData    <= 1'b0;
      o_FrameStart   <= 1'b0;
    end else begin
      state          <= state_next;
      beat           <= beat_next;
      front          <= front_next;
      back           <= back_next;
      pending        <= pending_next;
      o_ActiveBuffer <= active_next;
      command        <= command_d;
      data_write     <= data_write_d;
      fifo_data      <= fifo_data_d;
      fifo_write     <= fifo_write_d;
      o_Busy         <= busy_d;
      o_FillDone     <= fill_done_d;
      o_FirstData    <= first_d;
      o_FrameStart   <= frame_start_d;
    end
  end

endmodule
